uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx_pkg.sv | 16 +
 rtl/sync_2ff.sv | 26 ++
 rtl/uart_rx.sv | 127 ++++++++++++
 tb/tb_uart_rx.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared UART constants: default clock/baud rates, 8N1 frame shape and receiver FSM states.
package uart_rx_pkg;

   localparam int unsigned UART_CLOCK_RATE = 25_000_000;
   localparam int unsigned UART_BAUD_RATE  = 57_600;
   localparam int unsigned UART_DATA_BITS  = 8;
   localparam logic        UART_STOP_LEVEL = 1'b1;

   typedef enum logic [1:0] {
      StIdle,
      StStart,
      StData,
      StStop
   } rx_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit, with a selectable reset level.
module sync_2ff #(
   parameter logic ResetVal = 1'b0
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         meta_q <= ResetVal;
         sync_q <= ResetVal;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: start-bit validation at mid-bit, centre sampling of data and stop bits.
module uart_rx
   import uart_rx_pkg::*;
#(
   parameter int unsigned CLOCK_RATE   = UART_CLOCK_RATE,
   parameter int unsigned BAUD_RATE    = UART_BAUD_RATE,
   parameter int unsigned CLKS_PER_BIT = CLOCK_RATE / BAUD_RATE
) (
   input  logic                      CLK,
   input  logic                      RESET,
   input  logic                      RX,
   output logic [UART_DATA_BITS-1:0] DATA,
   output logic                      VALID,
   output logic                      FRAME_ERR,
   output logic                      BUSY
);

   localparam int unsigned IdxW = $clog2(UART_DATA_BITS);
   localparam logic [15:0] BitLast  = 16'(CLKS_PER_BIT - 1);
   localparam logic [15:0] HalfLast = 16'((CLKS_PER_BIT / 2) - 1);
   localparam logic [IdxW-1:0] IdxLast = IdxW'(UART_DATA_BITS - 1);

   logic rx_s;
   logic rx_prev_q;

   rx_state_e                 state_q, state_d;
   logic [15:0]               cnt_q, cnt_d;
   logic [IdxW-1:0]           idx_q, idx_d;
   logic [UART_DATA_BITS-1:0] shift_q, shift_d;
   logic [UART_DATA_BITS-1:0] data_q, data_d;
   logic                      valid_q, valid_d;
   logic                      ferr_q, ferr_d;

   sync_2ff #(
      .ResetVal (1'b1)
   ) u_sync (
      .clk_i (CLK),
      .rst_i (RESET),
      .d_i   (RX),
      .q_o   (rx_s)
   );

   always_ff @(posedge CLK) begin
      if (RESET) begin
         rx_prev_q <= 1'b1;
         state_q   <= StIdle;
         cnt_q     <= '0;
         idx_q     <= '0;
         shift_q   <= '0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         ferr_q    <= 1'b0;
      end else begin
         rx_prev_q <= rx_s;
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         shift_q   <= shift_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         ferr_q    <= ferr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      shift_d = shift_q;
      data_d  = data_q;
      valid_d = 1'b0;
      ferr_d  = 1'b0;

      unique case (state_q)
         StIdle: begin
            cnt_d = '0;
            idx_d = '0;
            // A line held low after a break never looks like a new falling edge.
            if (rx_prev_q && !rx_s) begin
               state_d = StStart;
            end
         end
         StStart: begin
            if (cnt_q >= HalfLast) begin
               cnt_d   = '0;
               state_d = rx_s ? StIdle : StData;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         StData: begin
            if (cnt_q >= BitLast) begin
               cnt_d          = '0;
               shift_d[idx_q] = rx_s;
               if (idx_q == IdxLast) begin
                  state_d = StStop;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         StStop: begin
            if (cnt_q >= BitLast) begin
               cnt_d   = '0;
               state_d = StIdle;
               if (rx_s == UART_STOP_LEVEL) begin
                  data_d  = shift_q;
                  valid_d = 1'b1;
               end else begin
                  ferr_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign DATA      = data_q;
   assign VALID     = valid_q;
   assign FRAME_ERR = ferr_q;
   assign BUSY      = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: nominal byte, back-to-back, glitch, framing error, reset abort, baud skew.
module tb_uart_rx;

   localparam int Cpb = 434;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       rx = 1'b1;
   logic [7:0] data;
   logic       valid;
   logic       frame_err;
   logic       busy;

   int n_total = 0;
   int n_bad   = 0;
   int cyc     = 0;
   int n_valid = 0;
   int n_ferr  = 0;
   int n_both  = 0;
   int valid_cyc = 0;
   logic [7:0] got_q[$];

   uart_rx dut (
      .CLK       (clk),
      .RESET     (reset),
      .RX        (rx),
      .DATA      (data),
      .VALID     (valid),
      .FRAME_ERR (frame_err),
      .BUSY      (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (valid) begin
         n_valid++;
         valid_cyc = cyc;
         got_q.push_back(data);
      end
      if (frame_err) n_ferr++;
      if (valid && frame_err) n_both++;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic idle(input int n);
      rx = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b, input int cpb, input logic stop);
      logic [9:0] frame;
      frame = {stop, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         rx = frame[i];
         repeat (cpb) @(negedge clk);
      end
   endtask

   initial begin
      int v0, f0, q0, t0;

      // Reset state
      repeat (4) @(negedge clk);
      check_eq("rst_data", data, 8'h00);
      check_eq("rst_valid", valid, 1'b0);
      check_eq("rst_ferr", frame_err, 1'b0);
      check_eq("rst_busy", busy, 1'b0);
      reset = 1'b0;
      idle(20);

      // Single byte A5, latency from first edge seeing RX low
      v0 = n_valid; f0 = n_ferr; q0 = got_q.size();
      t0 = cyc + 1;
      send_byte(8'hA5, Cpb, 1'b1);
      idle(50);
      check_eq("a5_count", n_valid - v0, 1);
      check_eq("a5_data", got_q[q0], 8'hA5);
      check_eq("a5_ferr", n_ferr - f0, 0);
      check_eq("a5_latency", valid_cyc - t0, 4125);
      check_eq("a5_data_hold", data, 8'hA5);

      // Back-to-back frames
      v0 = n_valid; q0 = got_q.size();
      send_byte(8'h00, Cpb, 1'b1);
      send_byte(8'hFF, Cpb, 1'b1);
      send_byte(8'h55, Cpb, 1'b1);
      idle(200);
      check_eq("b2b_count", n_valid - v0, 3);
      check_eq("b2b_0", got_q[q0], 8'h00);
      check_eq("b2b_1", got_q[q0+1], 8'hFF);
      check_eq("b2b_2", got_q[q0+2], 8'h55);

      // 100-clock glitch
      v0 = n_valid; f0 = n_ferr;
      rx = 1'b0;
      repeat (50) @(negedge clk);
      check_eq("glitch_busy_hi", busy, 1'b1);
      repeat (50) @(negedge clk);
      rx = 1'b1;
      repeat (130) @(negedge clk);
      check_eq("glitch_busy_lo", busy, 1'b0);
      idle(5000);
      check_eq("glitch_valid", n_valid - v0, 0);
      check_eq("glitch_ferr", n_ferr - f0, 0);

      // Framing error followed by a long break
      v0 = n_valid; f0 = n_ferr;
      send_byte(8'h3C, Cpb, 1'b0);
      rx = 1'b0;
      repeat (20 * Cpb) @(negedge clk);
      check_eq("ferr_count", n_ferr - f0, 1);
      check_eq("ferr_valid", n_valid - v0, 0);
      check_eq("ferr_data_kept", data, 8'h55);
      check_eq("ferr_both", n_both, 0);
      idle(2000);
      check_eq("ferr_recover_valid", n_valid - v0, 0);

      // Reset during data bit 4 of 81, then clean 42
      v0 = n_valid; f0 = n_ferr; q0 = got_q.size();
      rx = 1'b0;
      repeat (Cpb) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         rx = (i == 0);
         repeat (Cpb) @(negedge clk);
      end
      rx = 1'b0;
      repeat (200) @(negedge clk);
      reset = 1'b1;
      rx = 1'b1;
      repeat (5) @(negedge clk);
      reset = 1'b0;
      check_eq("abort_busy", busy, 1'b0);
      check_eq("abort_data", data, 8'h00);
      idle(1000);
      send_byte(8'h42, Cpb, 1'b1);
      idle(200);
      check_eq("abort_count", n_valid - v0, 1);
      check_eq("abort_ferr", n_ferr - f0, 0);
      check_eq("abort_byte", got_q[q0], 8'h42);

      // Baud skew +/-2%
      v0 = n_valid; f0 = n_ferr; q0 = got_q.size();
      send_byte(8'hC3, 425, 1'b1);
      idle(500);
      send_byte(8'h18, 443, 1'b1);
      idle(500);
      check_eq("skew_count", n_valid - v0, 2);
      check_eq("skew_fast", got_q[q0], 8'hC3);
      check_eq("skew_slow", got_q[q0+1], 8'h18);
      check_eq("skew_ferr", n_ferr - f0, 0);
      check_eq("never_both", n_both, 0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
